// File: rtl/conv1d_pkg.sv
// Shared types and constants for the 4-tap conv1d tap reader.
package conv1d_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        SAT  = 2'd2
    } state_t;

    localparam int N_TAPS = 4;
    localparam logic [2:0] BIAS_ADDR = 3'd4;

endpackage

// File: rtl/conv1d_tap_reader_if.sv
// Tap, weight-write and result bundle for conv1d_tap_reader.
interface conv1d_tap_reader_if #(
    parameter int W = 16
);
    logic                sample_clk;
    logic signed [W-1:0] tap0;
    logic signed [W-1:0] tap1;
    logic signed [W-1:0] tap2;
    logic signed [W-1:0] tap3;
    logic                wt_we;
    logic [2:0]          wt_addr;
    logic signed [W-1:0] wt_data;
    logic signed [W-1:0] sample_out;
    logic                out_valid;
    logic                busy;
    logic                overrun;

    modport master (
        output sample_clk, tap0, tap1, tap2, tap3,
        output wt_we, wt_addr, wt_data,
        input  sample_out, out_valid, busy, overrun
    );

    modport slave (
        input  sample_clk, tap0, tap1, tap2, tap3,
        input  wt_we, wt_addr, wt_data,
        output sample_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/conv1d_sat.sv
// Adds the bias, drops FRAC fractional bits (floor) and clamps to W bits.
module conv1d_sat #(
    parameter int IW   = 34,
    parameter int W    = 16,
    parameter int FRAC = 12
) (
    input  logic signed [IW-1:0] acc,
    input  logic signed [W-1:0]  bias,
    output logic signed [W-1:0]  y
);
    // One guard bit so the bias add can never wrap.
    localparam int SW = IW + 1;
    localparam logic signed [SW-1:0] MAXV = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shr;

    always_comb begin
        sum = $signed({acc[IW-1], acc})
            + ($signed({{(SW-W){bias[W-1]}}, bias}) <<< FRAC);
        shr = sum >>> FRAC;
        if (shr > MAXV) begin
            y = MAXV[W-1:0];
        end else if (shr < MINV) begin
            y = MINV[W-1:0];
        end else begin
            y = shr[W-1:0];
        end
    end
endmodule

// File: rtl/conv1d_tap_reader.sv
// 4-tap fixed-point FIR sampler: snapshot on sample_clk rise, 4-cycle MAC, saturate.
// Define CONV1D_RELU_EN to clamp negative results to zero.
module conv1d_tap_reader
    import conv1d_pkg::*;
#(
    parameter int W    = 16,
    parameter int FRAC = 12
) (
    input logic clk,
    input logic rst,
    conv1d_tap_reader_if.slave bus
);
    localparam int AW = 2*W + 2;
    localparam logic signed [W-1:0] ONE = W'(1 << FRAC);

    state_t state_q;
    state_t state_d;

    logic                 sclk_q;
    logic                 rise;
    logic                 wt_ok;
    logic [1:0]           k_q;
    logic signed [W-1:0]  snap [N_TAPS];
    logic signed [W-1:0]  wt   [N_TAPS];
    logic signed [W-1:0]  bias;
    logic signed [AW-1:0] acc;
    logic signed [2*W-1:0] prod;
    logic signed [W-1:0]  sat_y;
    logic signed [W-1:0]  res;

    assign rise     = bus.sample_clk & ~sclk_q;
    assign prod     = snap[k_q] * wt[k_q];
    assign wt_ok    = bus.wt_we & ~rise & (state_q == IDLE);
    assign bus.busy = (state_q != IDLE);

    conv1d_sat #(
        .IW  (AW),
        .W   (W),
        .FRAC(FRAC)
    ) u_sat (
        .acc (acc),
        .bias(bias),
        .y   (sat_y)
    );

`ifdef CONV1D_RELU_EN
    assign res = sat_y[W-1] ? '0 : sat_y;
`else
    assign res = sat_y;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = MAC;
            MAC:     if (k_q == 2'd3) state_d = SAT;
            SAT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q         <= 1'b0;
            k_q            <= '0;
            acc            <= '0;
            bias           <= '0;
            bus.sample_out <= '0;
            bus.out_valid  <= 1'b0;
            bus.overrun    <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                snap[i] <= '0;
                wt[i]   <= '0;
            end
            wt[0] <= ONE;
        end else begin
            sclk_q        <= bus.sample_clk;
            bus.out_valid <= 1'b0;
            // A rise while busy is dropped; the flag is sticky.
            if (rise && state_q != IDLE) begin
                bus.overrun <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        snap[0] <= bus.tap0;
                        snap[1] <= bus.tap1;
                        snap[2] <= bus.tap2;
                        snap[3] <= bus.tap3;
                        acc     <= '0;
                        k_q     <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + $signed({{(AW-2*W){prod[2*W-1]}}, prod});
                    k_q <= k_q + 2'd1;
                end
                SAT: begin
                    bus.sample_out <= res;
                    bus.out_valid  <= 1'b1;
                end
                default: ;
            endcase
            if (wt_ok) begin
                unique case (1'b1)
                    (bus.wt_addr < 3'(N_TAPS)):
                        wt[bus.wt_addr[1:0]] <= bus.wt_data;
                    (bus.wt_addr == BIAS_ADDR):
                        bias <= bus.wt_data;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_conv1d_tap_reader.sv
// Randomised self-checking bench for conv1d_tap_reader against a fixed-point model.
module tb_conv1d_tap_reader;
    localparam int W    = 16;
    localparam int FRAC = 12;

    logic clk = 1'b0;
    logic rst;

    conv1d_tap_reader_if #(.W(W)) bus ();

    conv1d_tap_reader #(
        .W   (W),
        .FRAC(FRAC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int mw[4];
    int mb;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model(input int t0, input int t1, input int t2, input int t3);
        longint x;
        x = longint'(t0) * mw[0] + longint'(t1) * mw[1]
          + longint'(t2) * mw[2] + longint'(t3) * mw[3];
        x = x + longint'(mb) * (longint'(1) << FRAC);
        x = x >>> FRAC;
        if (x > 32767) x = 32767;
        if (x < -32768) x = -32768;
`ifdef CONV1D_RELU_EN
        if (x < 0) x = 0;
`endif
        return int'(x);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        mw = '{4096, 0, 0, 0};
        mb = 0;
    endtask

    task automatic set_wt(input int a, input int d);
        bus.wt_we   = 1'b1;
        bus.wt_addr = 3'(a);
        bus.wt_data = W'(d);
        tick();
        bus.wt_we = 1'b0;
        if (a < 4) mw[a] = d;
        else if (a == 4) mb = d;
    endtask

    task automatic set_taps(input int t0, input int t1, input int t2, input int t3);
        bus.tap0 = W'(t0);
        bus.tap1 = W'(t1);
        bus.tap2 = W'(t2);
        bus.tap3 = W'(t3);
    endtask

    task automatic run_conv(input int t0, input int t1, input int t2, input int t3,
                            input bit scramble,
                            output int res, output int nvalid, output int lat);
        set_taps(t0, t1, t2, t3);
        bus.sample_clk = 1'b1;
        tick();
        bus.sample_clk = 1'b0;
        if (scramble) set_taps($urandom, $urandom, $urandom, $urandom);
        nvalid = 0;
        lat    = -1;
        res    = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.out_valid) begin
                nvalid++;
                if (lat < 0) begin
                    lat = c;
                    res = int'(bus.sample_out);
                end
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.sample_out !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_sample_out got %0d want 0", bus.sample_out);
        end
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.overrun} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 000",
                     {bus.out_valid, bus.busy, bus.overrun});
        end
    endtask

    task automatic test_passthrough();
        set_taps(1000, $urandom, $urandom, $urandom);
        bus.sample_clk = 1'b1;
        tick();
        bus.sample_clk = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) tick();
            n_checks++;
            if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL pass_busy_E%0d busy=%b valid=%b want 1/0",
                         c, bus.busy, bus.out_valid);
            end
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0 || bus.sample_out !== 16'sd1000) begin
            n_fail++;
            $display("FAIL pass_E5 valid=%b busy=%b out=%0d want 1/0/1000",
                     bus.out_valid, bus.busy, bus.sample_out);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.sample_out !== 16'sd1000) begin
            n_fail++;
            $display("FAIL pass_E6 valid=%b out=%0d want 0/1000",
                     bus.out_valid, bus.sample_out);
        end
    endtask

    task automatic test_weighted();
        int res, nv, lat;
        for (int i = 0; i < 4; i++) set_wt(i, 1024);
        set_wt(4, 0);
        run_conv(4000, -4000, 8000, 0, 1'b1, res, nv, lat);
        n_checks++;
        if (res !== 2000 || nv !== 1 || lat !== 5) begin
            n_fail++;
            $display("FAIL weighted got %0d n=%0d lat=%0d want 2000 n=1 lat=5", res, nv, lat);
        end
    endtask

    task automatic test_relu();
        int res, nv, lat, want;
`ifdef CONV1D_RELU_EN
        want = 0;
`else
        want = -1000;
`endif
        run_conv(-4000, 0, 0, 0, 1'b0, res, nv, lat);
        n_checks++;
        if (res !== want || nv !== 1) begin
            n_fail++;
            $display("FAIL relu got %0d n=%0d want %0d n=1", res, nv, want);
        end
    endtask

    task automatic test_saturation();
        int res, nv, lat;
        set_wt(0, 32767);
        for (int i = 1; i < 4; i++) set_wt(i, 0);
        run_conv(32767, 0, 0, 0, 1'b0, res, nv, lat);
        n_checks++;
        if (res !== 32767) begin
            n_fail++;
            $display("FAIL sat_hi got %0d want 32767", res);
        end
        run_conv(-32768, 0, 0, 0, 1'b0, res, nv, lat);
        n_checks++;
        if (res !== model(-32768, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL sat_lo got %0d want %0d", res, model(-32768, 0, 0, 0));
        end
    endtask

    task automatic test_overrun();
        int nv;
        set_taps(500, 0, 0, 0);
        bus.sample_clk = 1'b1;
        tick();
        bus.sample_clk = 1'b0;
        tick();
        bus.sample_clk = 1'b1;
        tick();
        bus.sample_clk = 1'b0;
        n_checks++;
        if (bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set got %b want 1", bus.overrun);
        end
        nv = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.out_valid) nv++;
        end
        n_checks++;
        if (nv !== 1) begin
            n_fail++;
            $display("FAIL overrun_pulses got %0d want 1", nv);
        end
        repeat (100) tick();
        n_checks++;
        if (bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky got %b want 1", bus.overrun);
        end
        do_reset();
        n_checks++;
        if (bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear got %b want 0", bus.overrun);
        end
    endtask

    task automatic test_reset_mid();
        int res, nv, lat;
        for (int i = 0; i < 4; i++) set_wt(i, 1024);
        set_taps(300, 300, 300, 300);
        bus.sample_clk = 1'b1;
        tick();
        bus.sample_clk = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mw = '{4096, 0, 0, 0};
        mb = 0;
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.out_valid) nv++;
        end
        n_checks++;
        if (nv !== 0 || bus.sample_out !== 16'sd0) begin
            n_fail++;
            $display("FAIL rst_mid n=%0d out=%0d want 0/0", nv, bus.sample_out);
        end
        run_conv(1234, 77, -77, 5000, 1'b0, res, nv, lat);
        n_checks++;
        if (res !== 1234 || nv !== 1) begin
            n_fail++;
            $display("FAIL rst_mid_next got %0d n=%0d want 1234 n=1", res, nv);
        end
    endtask

    task automatic test_ignored_writes();
        int res, nv, lat;
        set_taps(777, 1, 1, 1);
        bus.sample_clk = 1'b1;
        bus.wt_we      = 1'b1;
        bus.wt_addr    = 3'd0;
        bus.wt_data    = 16'sd0;
        tick();
        bus.sample_clk = 1'b0;
        bus.wt_addr    = 3'd1;
        bus.wt_data    = 16'sd4096;
        tick();
        bus.wt_addr = 3'd5;
        bus.wt_data = 16'sd4096;
        repeat (10) tick();
        bus.wt_addr = 3'd7;
        tick();
        bus.wt_we = 1'b0;
        run_conv(777, 1, 1, 1, 1'b0, res, nv, lat);
        n_checks++;
        if (res !== 777) begin
            n_fail++;
            $display("FAIL ignored_writes got %0d want 777", res);
        end
        set_wt(4, 3);
        run_conv(777, 1, 1, 1, 1'b0, res, nv, lat);
        n_checks++;
        if (res !== model(777, 1, 1, 1)) begin
            n_fail++;
            $display("FAIL bias_write got %0d want %0d", res, model(777, 1, 1, 1));
        end
    endtask

    task automatic test_random();
        int res, nv, lat, want;
        int t[4];
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 5; i++) set_wt(i, int'($signed(16'($urandom))));
            for (int i = 0; i < 4; i++) t[i] = int'($signed(16'($urandom)));
            want = model(t[0], t[1], t[2], t[3]);
            run_conv(t[0], t[1], t[2], t[3], 1'b1, res, nv, lat);
            n_checks++;
            if (res !== want || nv !== 1 || lat !== 5) begin
                n_fail++;
                $display("FAIL random_%0d got %0d n=%0d lat=%0d want %0d n=1 lat=5",
                         it, res, nv, lat, want);
            end
        end
    endtask

    initial begin
        bus.sample_clk = 1'b0;
        bus.wt_we      = 1'b0;
        bus.wt_addr    = '0;
        bus.wt_data    = '0;
        set_taps(0, 0, 0, 0);
        do_reset();
        test_reset();
        test_passthrough();
        test_weighted();
        test_relu();
        test_saturation();
        test_overrun();
        test_reset_mid();
        test_ignored_writes();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
